// File: rtl/tc_mem_arbiter.sv
// tc_mem_arbiter
//   Two-requester arbiter/sequencer in front of a single-port TC memory
//   (registered read on posedge, write on negedge). One transaction is in
//   flight at a time; each one ends with a single-cycle ack to its requester.
//
//   Build option:
//     TC_MEM_ARB_FIXED_PRIO_EN  defined   -> req0 always beats req1, no last pointer
//                               undefined -> round-robin between the two requesters
//
//   Sequencing (one IDLE cycle always separates transactions):
//     write : IDLE -> WRITE -> DONE -> IDLE
//     read  : IDLE -> RD_ISSUE -> RD_CAPTURE -> DONE -> IDLE
module tc_mem_arbiter #(
  parameter int BIT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [BIT_WIDTH-1:0]  wdata0,
  input  logic [BIT_WIDTH-1:0]  wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [BIT_WIDTH-1:0]  rdata,
  output logic                  busy,
  output logic                  mem_load,
  output logic                  mem_save,
  output logic [15:0]           mem_address,
  output logic [BIT_WIDTH-1:0]  mem_in,
  input  logic [BIT_WIDTH-1:0]  mem_out
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    RD_ISSUE   = 3'd2,
    RD_CAPTURE = 3'd3,
    DONE       = 3'd4
  } state_t;

  // One requester's command as seen at the grant edge.
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BIT_WIDTH-1:0]  wdata;
  } req_t;

  state_t state, state_nxt;

  req_t   rq [2];
  req_t   sel;
  logic   win;         // index of the requester granted this cycle
  logic   grant;       // a grant is taken at the closing edge of this cycle
  logic   cur;         // index of the requester that owns the transaction
  logic [15:0] sel_addr16;

`ifndef TC_MEM_ARB_FIXED_PRIO_EN
  logic   last;        // most recently granted requester
`endif

  assign rq[0] = '{we: we0, addr: addr0, wdata: wdata0};
  assign rq[1] = '{we: we1, addr: addr1, wdata: wdata1};
  assign sel   = rq[win];

  // The memory address pin is always 16 bits wide; narrower addresses are
  // zero-extended, wider ones keep their low 16 bits.
  generate
    if (ADDR_WIDTH >= 16) begin : g_addr_trunc
      assign sel_addr16 = sel.addr[15:0];
    end else begin : g_addr_ext
      assign sel_addr16 = {{(16-ADDR_WIDTH){1'b0}}, sel.addr};
    end
  endgenerate

  // Pick the winner among the pending requests.
  always_comb begin
    win = 1'b0;
`ifdef TC_MEM_ARB_FIXED_PRIO_EN
    win = !req0;
`else
    if (req0 && req1) win = !last;   // tie: whoever was not served last
    else              win = req1;    // a lone request always wins
`endif
  end

  assign grant = (state == IDLE) && (req0 || req1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (grant) state_nxt = sel.we ? WRITE : RD_ISSUE;
      WRITE:      state_nxt = DONE;
      RD_ISSUE:   state_nxt = RD_CAPTURE;
      RD_CAPTURE: state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Memory strobes, ack and busy are pure functions of the registered state,
  // so a reset during WRITE leaves mem_save high for that whole cycle and the
  // negedge commit still happens.
  always_comb begin
    mem_save = (state == WRITE);
    mem_load = (state == RD_ISSUE);
    busy     = (state != IDLE);
    ack0     = (state == DONE) && !cur;
    ack1     = (state == DONE) &&  cur;
  end

  // Grant latching and read-data capture. mem_address / mem_in double as the
  // latched command so they naturally hold their values between transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= 1'b0;
      mem_address <= '0;
      mem_in      <= '0;
      rdata       <= '0;
    end else begin
      if (grant) begin
        cur         <= win;
        mem_address <= sel_addr16;
        if (sel.we) mem_in <= sel.wdata;
      end
      if (state == RD_CAPTURE) rdata <= mem_out;
    end
  end

`ifndef TC_MEM_ARB_FIXED_PRIO_EN
  // Round-robin pointer; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)        last <= 1'b1;
    else if (grant) last <= win;
  end
`endif

endmodule

// File: tb/tb_tc_mem_arbiter.sv
// Bench for tc_mem_arbiter: directed scenarios followed by a randomized run,
// all checked cycle by cycle against a transaction-level reference model.
module tb_tc_mem_arbiter;
  localparam int BW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [BW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy, mem_load, mem_save;
  logic [BW-1:0] rdata, mem_in, mem_out;
  logic [15:0]   mem_address;

  tc_mem_arbiter #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_load(mem_load), .mem_save(mem_save), .mem_address(mem_address),
    .mem_in(mem_in), .mem_out(mem_out)
  );

  // TC memory: registered read on posedge (0 when load is low), write on negedge.
  logic [BW-1:0] phys [0:65535];
  logic          pl_en;
  logic [15:0]   pl_addr;
  logic [BW-1:0] pl_data;
  always @(negedge clk) begin
    if (pl_en)         phys[pl_addr]     <= pl_data;
    else if (mem_save) phys[mem_address] <= mem_in;
  end
  always @(posedge clk) mem_out <= mem_load ? phys[mem_address] : '0;

  function automatic logic [BW-1:0] pre(int a);
    logic [15:0] v;
    v = 16'(a);
    if (a == 'h10) return 16'h1111;
    if (a == 'h20) return 16'h2222;
    return {v[7:0], 8'hC3};
  endfunction

  // Reference model: each grant expands into the pin behaviour of the
  // following cycles (strobe cycle(s), ack cycle, mandatory idle cycle).
  typedef struct {
    bit            busy, save, load, ack0, ack1, set_rd;
    logic [BW-1:0] rd;
  } exp_t;
  typedef struct {
    bit            who;
    logic [BW-1:0] data;
  } ack_t;

  exp_t          q[$];
  exp_t          e_now;
  ack_t          alog[$];
  logic [BW-1:0] ref_mem [0:255];
  bit            m_last;
  logic [15:0]   m_addr;
  logic [BW-1:0] m_in, m_rdata;
  int            checks = 0;
  int            failures = 0;

  function automatic exp_t mk(bit b, bit s, bit l, bit a0, bit a1, bit sr, logic [BW-1:0] rd);
    exp_t e;
    e.busy = b; e.save = s; e.load = l; e.ack0 = a0; e.ack1 = a1; e.set_rd = sr; e.rd = rd;
    return e;
  endfunction

  task automatic predict();
    bit            w;
    logic          wwe;
    logic [15:0]   a;
    logic [BW-1:0] d;
    if (rst) begin
      q.delete();
      m_last = 1'b1; m_addr = '0; m_in = '0; m_rdata = '0;
      e_now = mk(0, 0, 0, 0, 0, 0, '0);
      return;
    end
    if (q.size() == 0 && (req0 || req1)) begin
`ifdef TC_MEM_ARB_FIXED_PRIO_EN
      w = !req0;
`else
      w = (req0 && req1) ? !m_last : req1;
`endif
      wwe = w ? we1 : we0;
      a   = w ? addr1 : addr0;
      d   = w ? wdata1 : wdata0;
      m_last = w;
      m_addr = a;
      if (wwe) begin
        m_in = d;
        ref_mem[a[7:0]] = d;
        q.push_back(mk(1, 1, 0, 0, 0, 0, '0));
        q.push_back(mk(1, 0, 0, !w, w, 0, '0));
      end else begin
        q.push_back(mk(1, 0, 1, 0, 0, 0, '0));
        q.push_back(mk(1, 0, 0, 0, 0, 0, '0));
        q.push_back(mk(1, 0, 0, !w, w, 1, ref_mem[a[7:0]]));
      end
      q.push_back(mk(0, 0, 0, 0, 0, 0, '0));
    end
    if (q.size() > 0) e_now = q.pop_front();
    else              e_now = mk(0, 0, 0, 0, 0, 0, '0);
    if (e_now.set_rd) m_rdata = e_now.rd;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock and compare every output against the model.
  task automatic cyc();
    predict();
    @(posedge clk);
    #1;
    chk("busy",     32'(busy),        32'(e_now.busy));
    chk("mem_save", 32'(mem_save),    32'(e_now.save));
    chk("mem_load", 32'(mem_load),    32'(e_now.load));
    chk("ack0",     32'(ack0),        32'(e_now.ack0));
    chk("ack1",     32'(ack1),        32'(e_now.ack1));
    chk("mem_addr", 32'(mem_address), 32'(m_addr));
    chk("mem_in",   32'(mem_in),      32'(m_in));
    chk("rdata",    32'(rdata),       32'(m_rdata));
    if (ack0 || ack1) alog.push_back('{ack1, rdata});
  endtask

  task automatic run_until(int n);
    for (int k = 0; k < 60; k++) begin
      if (alog.size() >= n) break;
      cyc();
    end
  endtask

  task automatic set0(bit r, bit w, logic [AW-1:0] a, logic [BW-1:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask
  task automatic set1(bit r, bit w, logic [AW-1:0] a, logic [BW-1:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  initial begin
    rst = 1'b1;
    set0(0, 0, '0, '0);
    set1(0, 0, '0, '0);
    pl_en = 1'b1; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 256; i++) begin
      pl_addr = 16'(i); pl_data = pre(i); ref_mem[i] = pre(i);
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    // reset state
    cyc(); cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdata", 32'(rdata), 0);
    rst = 1'b0;

    // write then read, requester 0
    alog.delete();
    set0(1, 1, 16'h0005, 16'hBEEF);
    cyc();
    chk("t1_save_on", 32'(mem_save), 1);
    set0(0, 0, '0, '0);
    cyc();
    chk("t1_wr_ack0", 32'(ack0), 1);
    chk("t1_save_off", 32'(mem_save), 0);
    cyc();
    set0(1, 0, 16'h0005, '0);
    cyc();
    set0(0, 0, '0, '0);
    cyc(); cyc();
    chk("t1_rd_ack0", 32'(ack0), 1);
    chk("t1_rd_data", 32'(rdata), 32'h0000BEEF);
    cyc();
    chk("t1_n_acks", 32'(alog.size()), 2);
    for (int k = 0; k < alog.size(); k++) chk("t1_who", 32'(alog[k].who), 0);

    // simultaneous requests from reset
    rst = 1'b1; cyc(); rst = 1'b0;
    alog.delete();
    set0(1, 0, 16'h0010, '0);
    set1(1, 0, 16'h0020, '0);
    run_until(4);
    set0(0, 0, '0, '0); set1(0, 0, '0, '0);
    cyc(); cyc();
    chk("t2_n_acks", 32'(alog.size()), 4);
    for (int k = 0; k < alog.size() && k < 4; k++) begin
`ifdef TC_MEM_ARB_FIXED_PRIO_EN
      chk("t2_who", 32'(alog[k].who), 0);
      chk("t2_data", 32'(alog[k].data), 32'h1111);
`else
      chk("t2_who", 32'(alog[k].who), 32'(k % 2));
      chk("t2_data", 32'(alog[k].data), (k % 2) ? 32'h2222 : 32'h1111);
`endif
    end

    // input change after grant
    alog.delete();
    set1(1, 0, 16'h0030, '0);
    cyc();
    set1(1, 1, 16'h0031, 16'hDEAD);
    run_until(1);
    set1(0, 0, '0, '0);
    cyc(); cyc();
    chk("t3_n_acks", 32'(alog.size()), 1);
    if (alog.size() > 0) chk("t3_data", 32'(alog[0].data), 32'h30C3);

    // reset mid-read (during RD_CAPTURE)
    alog.delete();
    set0(1, 0, 16'h0010, '0);
    cyc();
    set0(0, 0, '0, '0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_addr", 32'(mem_address), 0);
    cyc(); cyc(); cyc();
    chk("t4_no_ack", 32'(alog.size()), 0);
    set0(1, 0, 16'h0020, '0);
    run_until(1);
    set0(0, 0, '0, '0);
    cyc();
    chk("t4_after_n", 32'(alog.size()), 1);
    if (alog.size() > 0) chk("t4_after_data", 32'(alog[0].data), 32'h2222);

    // reset in the WRITE cycle
    alog.delete();
    set0(1, 1, 16'h0007, 16'hA5A5);
    cyc();
    rst = 1'b1;
    set0(0, 0, '0, '0);
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    chk("t5_no_ack", 32'(alog.size()), 0);
    set0(1, 0, 16'h0007, '0);
    run_until(1);
    set0(0, 0, '0, '0);
    cyc();
    chk("t5_rd_n", 32'(alog.size()), 1);
    if (alog.size() > 0) chk("t5_rd_data", 32'(alog[0].data), 32'hA5A5);

    // lone request after a tie (last grant was requester 0)
    alog.delete();
    set0(1, 0, 16'h0010, '0);
    set1(1, 0, 16'h0020, '0);
    run_until(1);
    set0(0, 0, '0, '0); set1(0, 0, '0, '0);
    cyc();
`ifdef TC_MEM_ARB_FIXED_PRIO_EN
    if (alog.size() > 0) chk("t6_tie_who", 32'(alog[0].who), 0);
`else
    if (alog.size() > 0) chk("t6_tie_who", 32'(alog[0].who), 1);
`endif
    alog.delete();
    set1(1, 0, 16'h0020, '0);
    run_until(1);
    set1(0, 0, '0, '0);
    cyc();
    chk("t6_lone_n", 32'(alog.size()), 1);
    if (alog.size() > 0) begin
      chk("t6_lone_who", 32'(alog[0].who), 1);
      chk("t6_lone_data", 32'(alog[0].data), 32'h2222);
    end

    // randomized traffic, occasional resets, inputs changing every cycle
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      set0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           16'($urandom_range(0, 63)), 16'($urandom));
      set1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           16'($urandom_range(0, 63)), 16'($urandom));
      cyc();
    end
    rst = 1'b0;
    set0(0, 0, '0, '0); set1(0, 0, '0, '0);
    for (int n = 0; n < 5; n++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
